// File: rtl/parser_bus_arbiter.sv
// Round-robin, lock-until-done arbiter sharing one bit-reader between NUM_REQ OBU sub-parsers.
// Optional stall watchdog enabled by defining PARSER_ARB_WATCHDOG_EN.
package obu_parser_pkg;
  localparam int PARSER_DATA_WIDTH = 32;
  localparam int PAD_LEN_WIDTH     = 6;
endpackage

module parser_bus_arbiter
  import obu_parser_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PARSER_DATA_WIDTH-1:0]       data_in,
  input  logic                               avail,
  output logic                               pad,
  output logic [PAD_LEN_WIDTH-1:0]           pad_len,
  output logic                               pop,
  input  logic [NUM_REQ-1:0]                 req,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [NUM_REQ-1:0]                 p_start,
  output logic [PARSER_DATA_WIDTH-1:0]       p_data,
  output logic [NUM_REQ-1:0]                 p_avail,
  input  logic [NUM_REQ-1:0]                 p_done,
  input  logic [NUM_REQ-1:0]                 p_pad,
  input  logic [NUM_REQ*PAD_LEN_WIDTH-1:0]   p_pad_len,
  input  logic [NUM_REQ-1:0]                 p_pop,
  output logic                               busy,
  output logic                               wdog_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    ACTIVE,
    RELEASE
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   g_reg, g_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               owner_pad, owner_pop;
  logic               wdog_hit;
  logic [PAD_LEN_WIDTH-1:0] slice_len [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_len_unpack
      assign slice_len[gi] = p_pad_len[gi*PAD_LEN_WIDTH +: PAD_LEN_WIDTH];
    end
  endgenerate

  assign p_data = data_in;

  // Pad has priority over pop; both require a valid window.
  assign owner_pad = p_pad[g_reg] & avail;
  assign owner_pop = p_pop[g_reg] & avail & ~p_pad[g_reg];

  // Scan from the highest offset down so the offset closest to rr_ptr wins.
  always_comb begin
    int idx;
    sel_idx   = '0;
    sel_valid = 1'b0;
    idx       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IDX_W'(idx)]) begin
        sel_idx   = IDX_W'(idx);
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    g_next      = g_reg;
    rr_ptr_next = rr_ptr_reg;
    grant       = '0;
    p_start     = '0;
    p_avail     = '0;
    pad         = 1'b0;
    pad_len     = '0;
    pop         = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          g_next     = sel_idx;
          state_next = START;
        end
      end
      START: begin
        grant[g_reg]   = 1'b1;
        p_start[g_reg] = 1'b1;
        busy           = 1'b1;
        state_next     = ACTIVE;
      end
      ACTIVE: begin
        grant[g_reg]   = 1'b1;
        p_avail[g_reg] = avail;
        busy           = 1'b1;
        pad            = owner_pad;
        pop            = owner_pop;
        if (owner_pad) pad_len = slice_len[g_reg];
        if (p_done[g_reg] || wdog_hit) state_next = RELEASE;
      end
      RELEASE: begin
        rr_ptr_next = (g_reg == IDX_W'(NUM_REQ - 1)) ? '0 : g_reg + 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      g_reg      <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      g_reg      <= g_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

`ifdef PARSER_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_reg, wdog_cnt_next;
  logic             wdog_err_reg;
  logic             stall_cycle;

  assign stall_cycle = (state_reg == ACTIVE) && avail && !owner_pad && !owner_pop;
  assign wdog_hit    = stall_cycle && (wdog_cnt_reg == CNT_W'(WDOG_CYCLES - 1));

  // Cycles with avail=0 neither advance nor clear the stall count.
  always_comb begin
    wdog_cnt_next = wdog_cnt_reg;
    if (state_reg != ACTIVE || owner_pad || owner_pop || wdog_hit)
      wdog_cnt_next = '0;
    else if (stall_cycle)
      wdog_cnt_next = wdog_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_next;
      wdog_err_reg <= wdog_err_reg | wdog_hit;
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0 && (WDOG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_parser_bus_arbiter.sv
// Directed bench for parser_bus_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_parser_bus_arbiter;
  import obu_parser_pkg::*;

  localparam int N  = 4;
  localparam int LW = PAD_LEN_WIDTH;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [PARSER_DATA_WIDTH-1:0] data_in;
  logic                         avail;
  logic                         pad;
  logic [LW-1:0]                pad_len;
  logic                         pop;
  logic [N-1:0]                 req, grant, p_start, p_avail, p_done, p_pad, p_pop;
  logic [PARSER_DATA_WIDTH-1:0] p_data;
  logic [N*LW-1:0]              p_pad_len;
  logic                         busy, wdog_err;

  int checks = 0;
  int errors = 0;

  parser_bus_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .avail(avail),
    .pad(pad), .pad_len(pad_len), .pop(pop),
    .req(req), .grant(grant), .p_start(p_start), .p_data(p_data),
    .p_avail(p_avail), .p_done(p_done), .p_pad(p_pad), .p_pad_len(p_pad_len),
    .p_pop(p_pop), .busy(busy), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [N-1:0]    req;
    logic            avail;
    logic [N-1:0]    done;
    logic [N-1:0]    ppad;
    logic [N-1:0]    ppop;
    logic [N*LW-1:0] plen;
    logic [N-1:0]    e_grant;
    logic [N-1:0]    e_start;
    logic [N-1:0]    e_avail;
    logic            e_pad;
    logic [LW-1:0]   e_len;
    logic            e_pop;
    logic            e_busy;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*LW-1:0] pl(input int slot, input int len);
    logic [N*LW-1:0] v;
    v = '0;
    v[slot*LW +: LW] = LW'(len);
    return v;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] r, input logic a, input logic [N-1:0] d,
                              input logic [N-1:0] pp, input logic [N-1:0] po,
                              input logic [N*LW-1:0] ln, input logic [N-1:0] eg,
                              input logic [N-1:0] es, input logic [N-1:0] ea, input logic epd,
                              input int el, input logic epo, input logic eb);
    vec_t v;
    v.req = r; v.avail = a; v.done = d; v.ppad = pp; v.ppop = po; v.plen = ln;
    v.e_grant = eg; v.e_start = es; v.e_avail = ea; v.e_pad = epd;
    v.e_len = LW'(el); v.e_pop = epo; v.e_busy = eb;
    return v;
  endfunction

  task automatic clear_inputs();
    req = '0; avail = 1'b0; p_done = '0; p_pad = '0; p_pop = '0; p_pad_len = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [N-1:0] order [5];
  int gap;

  initial begin
    data_in = 32'hA5A5_0F0F;
    rst = 1'b0;
    clear_inputs();

    // Per-cycle table: test 1 (grant/pad), 3 (avail gating, pad priority),
    // 4 (done-cycle consumption, release), done-in-START ignored, owner req drop ignored.
    vecs[0]  = mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, '0,         4'b0000, 4'b0000, 4'b0000, 0, 0,  0, 0);
    vecs[1]  = mk(4'b0010, 1, 4'b0000, 4'b0010, 4'b0000, pl(1, 14),  4'b0010, 4'b0010, 4'b0000, 0, 0,  0, 1);
    vecs[2]  = mk(4'b0010, 1, 4'b0000, 4'b0010, 4'b0000, pl(1, 14),  4'b0010, 4'b0000, 4'b0010, 1, 14, 0, 1);
    vecs[3]  = mk(4'b0010, 0, 4'b0000, 4'b0000, 4'b0010, '0,         4'b0010, 4'b0000, 4'b0000, 0, 0,  0, 1);
    vecs[4]  = mk(4'b0010, 1, 4'b0000, 4'b0000, 4'b0010, '0,         4'b0010, 4'b0000, 4'b0010, 0, 0,  1, 1);
    vecs[5]  = mk(4'b0010, 1, 4'b0000, 4'b0010, 4'b0010, pl(1, 5),   4'b0010, 4'b0000, 4'b0010, 1, 5,  0, 1);
    vecs[6]  = mk(4'b0010, 1, 4'b0001, 4'b0100, 4'b0001, pl(2, 7),   4'b0010, 4'b0000, 4'b0010, 0, 0,  0, 1);
    vecs[7]  = mk(4'b0010, 1, 4'b0010, 4'b0010, 4'b0000, pl(1, 29),  4'b0010, 4'b0000, 4'b0010, 1, 29, 0, 1);
    vecs[8]  = mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, '0,         4'b0000, 4'b0000, 4'b0000, 0, 0,  0, 0);
    vecs[9]  = mk(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, '0,         4'b0000, 4'b0000, 4'b0000, 0, 0,  0, 0);
    vecs[10] = mk(4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, '0,         4'b0001, 4'b0001, 4'b0000, 0, 0,  0, 1);
    vecs[11] = mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, '0,         4'b0001, 4'b0000, 4'b0000, 0, 0,  0, 1);
    vecs[12] = mk(4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, '0,         4'b0001, 4'b0000, 4'b0001, 0, 0,  0, 1);
    vecs[13] = mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, '0,         4'b0000, 4'b0000, 4'b0000, 0, 0,  0, 0);
    vecs[14] = mk(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, '0,         4'b0000, 4'b0000, 4'b0000, 0, 0,  0, 0);

    // Reset state
    reset_dut();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_p_start", 32'(p_start), 32'h0);
    chk("rst_p_avail", 32'(p_avail), 32'h0);
    chk("rst_pad", 32'(pad), 32'h0);
    chk("rst_pad_len", 32'(pad_len), 32'h0);
    chk("rst_pop", 32'(pop), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wdog_err", 32'(wdog_err), 32'h0);
    chk("p_data", p_data, 32'hA5A5_0F0F);

    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req; avail = vecs[i].avail; p_done = vecs[i].done;
      p_pad = vecs[i].ppad; p_pop = vecs[i].ppop; p_pad_len = vecs[i].plen;
      #1;
      $display("vec %0d: grant=%b start=%b p_avail=%b pad=%b len=%0d pop=%b busy=%b",
               i, grant, p_start, p_avail, pad, pad_len, pop, busy);
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d_p_start", i), 32'(p_start), 32'(vecs[i].e_start));
      chk($sformatf("v%0d_p_avail", i), 32'(p_avail), 32'(vecs[i].e_avail));
      chk($sformatf("v%0d_pad", i), 32'(pad), 32'(vecs[i].e_pad));
      chk($sformatf("v%0d_pad_len", i), 32'(pad_len), 32'(vecs[i].e_len));
      chk($sformatf("v%0d_pop", i), 32'(pop), 32'(vecs[i].e_pop));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      tick();
    end

    // Round-robin order with all requesters held, done 3 cycles after start
    reset_dut();
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gap = 0;
      do begin
        tick();
        p_done = '0;
        gap++;
      end while (grant == '0 && gap < 20);
      $display("rr %0d: grant=%b after %0d idle cycles", k, grant, gap - 1);
      chk($sformatf("rr%0d_gap", k), 32'(gap - 1), (k == 0) ? 32'd0 : 32'd2);
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(order[k]));
      chk($sformatf("rr%0d_p_start", k), 32'(p_start), 32'(order[k]));
      tick(); tick(); tick();
      chk($sformatf("rr%0d_held", k), 32'(grant), 32'(order[k]));
      p_done = order[k];
    end
    tick();
    p_done = '0;
    req = '0;

    // Asynchronous reset while parser 2 is active
    reset_dut();
    req = 4'b0100;
    tick();
    tick();
    avail = 1'b1; p_pad = 4'b0100; p_pad_len = pl(2, 9);
    #1;
    $display("arst: pre-reset grant=%b pad=%b len=%0d", grant, pad, pad_len);
    chk("arst_pre_pad", 32'(pad), 32'h1);
    chk("arst_pre_len", 32'(pad_len), 32'd9);
    #2;
    rst = 1'b1;
    #1;
    $display("arst: in reset grant=%b pad=%b busy=%b", grant, pad, busy);
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_pad", 32'(pad), 32'h0);
    chk("arst_pad_len", 32'(pad_len), 32'h0);
    chk("arst_p_avail", 32'(p_avail), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    #1;
    rst = 1'b0;
    clear_inputs();
    req = 4'b1100;
    tick();
    $display("arst: after release grant=%b start=%b", grant, p_start);
    chk("arst_regrant", 32'(grant), 32'h4);
    chk("arst_restart", 32'(p_start), 32'h4);

    // Stalled owner: watchdog release or indefinite hold
    reset_dut();
    req = 4'b0011;
    tick();
    tick();
    avail = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 0) chk("wd_p_avail", 32'(p_avail), 32'h1);
      if (i == 7) begin
        chk("wd_pre_grant", 32'(grant), 32'h1);
        chk("wd_pre_err", 32'(wdog_err), 32'h0);
      end
      tick();
    end
    $display("wdog: after stall grant=%b wdog_err=%b", grant, wdog_err);
`ifdef PARSER_ARB_WATCHDOG_EN
    chk("wd_err", 32'(wdog_err), 32'h1);
    chk("wd_grant_drop", 32'(grant), 32'h0);
    chk("wd_p_avail_drop", 32'(p_avail), 32'h0);
    tick();
    tick();
    $display("wdog: next owner grant=%b wdog_err=%b", grant, wdog_err);
    chk("wd_next_grant", 32'(grant), 32'h2);
    chk("wd_err_sticky", 32'(wdog_err), 32'h1);
`else
    chk("wd_off_err", 32'(wdog_err), 32'h0);
    chk("wd_off_grant", 32'(grant), 32'h1);
    tick(); tick(); tick();
    $display("wdog off: later grant=%b wdog_err=%b", grant, wdog_err);
    chk("wd_off_grant_later", 32'(grant), 32'h1);
    chk("wd_off_p_avail", 32'(p_avail), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
